// File: rtl/vga_tile_timing_if.sv
// rtl/vga_tile_timing_if.sv - pixel-timing bundle between the VGA/tile timing generator and its renderers
//
// Signals (master = timing generator, slave = renderer / pixel-strobe source):
//   pix_en       pixel strobe into the generator
//   h_cnt/v_cnt  frame column / line of the current pixel
//   hsync/vsync  active-low sync pulses
//   active       pixel is inside the visible 640x480 area
//   frame_start  pixel (0,0) marker
//   tile_valid   pixel lies inside one of the 16 board tiles
//   tile_col/row tile index, 0..3
//   tile_h_cnt/tile_v_cnt  position inside the tile
interface vga_tile_timing_if;
  logic        pix_en;
  logic [11:0] h_cnt;
  logic [11:0] v_cnt;
  logic        hsync;
  logic        vsync;
  logic        active;
  logic        frame_start;
  logic        tile_valid;
  logic [1:0]  tile_col;
  logic [1:0]  tile_row;
  logic [11:0] tile_h_cnt;
  logic [11:0] tile_v_cnt;

  modport master (
    input  pix_en,
    output h_cnt, v_cnt, hsync, vsync, active, frame_start,
    output tile_valid, tile_col, tile_row, tile_h_cnt, tile_v_cnt
  );

  modport slave (
    output pix_en,
    input  h_cnt, v_cnt, hsync, vsync, active, frame_start,
    input  tile_valid, tile_col, tile_row, tile_h_cnt, tile_v_cnt
  );
endinterface

// File: rtl/vga_tile_timing.sv
// rtl/vga_tile_timing.sv - VGA 640x480@60 timing generator with 4x4 tile-board coordinates
//
// Ports:
//   clk  system clock
//   rst  synchronous reset, active-low
//   vif  vga_tile_timing_if.master: pix_en in; frame counters, syncs, active,
//        frame_start and tile coordinates out, all registered and describing
//        the same pixel in the same cycle.
module vga_tile_timing #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int TILE     = 106,
  parameter int GAP      = 8,
  parameter int BOARD_X0 = 88,
  parameter int BOARD_Y0 = 8
) (
  input  logic               clk,
  input  logic               rst,
  vga_tile_timing_if.master  vif
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [11:0] H_LAST    = 12'(H_TOTAL - 1);
  localparam logic [11:0] V_LAST    = 12'(V_TOTAL - 1);
  localparam logic [11:0] H_ACT     = 12'(H_ACTIVE);
  localparam logic [11:0] V_ACT     = 12'(V_ACTIVE);
  localparam logic [11:0] HS_START  = 12'(H_ACTIVE + H_FP);
  localparam logic [11:0] HS_END    = 12'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [11:0] VS_START  = 12'(V_ACTIVE + V_FP);
  localparam logic [11:0] VS_END    = 12'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [11:0] XS0       = 12'(BOARD_X0 + GAP);
  localparam logic [11:0] YS0       = 12'(BOARD_Y0 + GAP);
  localparam logic [11:0] TILE_LAST = 12'(TILE - 1);
  localparam logic [11:0] GAP_LAST  = 12'(GAP - 1);

  typedef enum logic [1:0] {
    ST_PRE  = 2'd0,
    ST_TILE = 2'd1,
    ST_GAP  = 2'd2,
    ST_DONE = 2'd3
  } axis_st_t;

  // Registered state; the axis FSM registers always describe the pixel
  // currently presented on h_cnt/v_cnt.
  logic [11:0] h_cnt, v_cnt;
  axis_st_t    h_st, v_st;
  logic [11:0] h_off, v_off;
  logic [1:0]  h_idx, v_idx;
  logic        hsync, vsync, active, frame_start, tile_valid;
  logic [1:0]  tile_col, tile_row;
  logic [11:0] tile_h_cnt, tile_v_cnt;

  // Next-pixel values; every output register is loaded from these so all
  // outputs move together with zero relative latency.
  logic        h_wrap, v_wrap;
  logic [11:0] h_nxt, v_nxt;
  axis_st_t    h_st_n, v_st_n;
  logic [11:0] h_off_n, v_off_n;
  logic [1:0]  h_idx_n, v_idx_n;
  logic        tv_n;

  always_comb begin
    h_wrap = (h_cnt == H_LAST);
    v_wrap = (v_cnt == V_LAST);
    h_nxt  = h_wrap ? 12'd0 : h_cnt + 12'd1;
    v_nxt  = v_cnt;
    if (h_wrap) begin
      v_nxt = v_wrap ? 12'd0 : v_cnt + 12'd1;
    end
  end

  // Horizontal axis: steps on every pixel, restarts on the line wrap.
  always_comb begin
    h_st_n  = h_st;
    h_off_n = h_off;
    h_idx_n = h_idx;
    if (h_wrap) begin
      h_off_n = 12'd0;
      h_idx_n = 2'd0;
      h_st_n  = (XS0 == 12'd0) ? ST_TILE : ST_PRE;
    end else begin
      case (h_st)
        ST_PRE: begin
          if (h_nxt == XS0) begin
            h_st_n  = ST_TILE;
            h_off_n = 12'd0;
          end
        end
        ST_TILE: begin
          if (h_off == TILE_LAST) begin
            h_off_n = 12'd0;
            h_st_n  = (h_idx == 2'd3) ? ST_DONE : ST_GAP;
          end else begin
            h_off_n = h_off + 12'd1;
          end
        end
        ST_GAP: begin
          if (h_off == GAP_LAST) begin
            h_off_n = 12'd0;
            h_idx_n = h_idx + 2'd1;
            h_st_n  = ST_TILE;
          end else begin
            h_off_n = h_off + 12'd1;
          end
        end
        default: ;
      endcase
    end
  end

  // Vertical axis: same walk, but only advances when the line wraps.
  always_comb begin
    v_st_n  = v_st;
    v_off_n = v_off;
    v_idx_n = v_idx;
    if (h_wrap) begin
      if (v_wrap) begin
        v_off_n = 12'd0;
        v_idx_n = 2'd0;
        v_st_n  = (YS0 == 12'd0) ? ST_TILE : ST_PRE;
      end else begin
        case (v_st)
          ST_PRE: begin
            if (v_nxt == YS0) begin
              v_st_n  = ST_TILE;
              v_off_n = 12'd0;
            end
          end
          ST_TILE: begin
            if (v_off == TILE_LAST) begin
              v_off_n = 12'd0;
              v_st_n  = (v_idx == 2'd3) ? ST_DONE : ST_GAP;
            end else begin
              v_off_n = v_off + 12'd1;
            end
          end
          ST_GAP: begin
            if (v_off == GAP_LAST) begin
              v_off_n = 12'd0;
              v_idx_n = v_idx + 2'd1;
              v_st_n  = ST_TILE;
            end else begin
              v_off_n = v_off + 12'd1;
            end
          end
          default: ;
        endcase
      end
    end
    tv_n = (h_st_n == ST_TILE) && (v_st_n == ST_TILE);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      // Park on the last pixel of the frame so the first pix_en lands on (0,0).
      h_cnt       <= H_LAST;
      v_cnt       <= V_LAST;
      h_st        <= ST_DONE;
      v_st        <= ST_DONE;
      h_off       <= 12'd0;
      v_off       <= 12'd0;
      h_idx       <= 2'd0;
      v_idx       <= 2'd0;
      hsync       <= 1'b1;
      vsync       <= 1'b1;
      active      <= 1'b0;
      frame_start <= 1'b0;
      tile_valid  <= 1'b0;
      tile_col    <= 2'd0;
      tile_row    <= 2'd0;
      tile_h_cnt  <= 12'd0;
      tile_v_cnt  <= 12'd0;
    end else if (vif.pix_en) begin
      h_cnt       <= h_nxt;
      v_cnt       <= v_nxt;
      h_st        <= h_st_n;
      v_st        <= v_st_n;
      h_off       <= h_off_n;
      v_off       <= v_off_n;
      h_idx       <= h_idx_n;
      v_idx       <= v_idx_n;
      hsync       <= !((h_nxt >= HS_START) && (h_nxt < HS_END));
      vsync       <= !((v_nxt >= VS_START) && (v_nxt < VS_END));
      active      <= (h_nxt < H_ACT) && (v_nxt < V_ACT);
      frame_start <= (h_nxt == 12'd0) && (v_nxt == 12'd0);
      tile_valid  <= tv_n;
      tile_col    <= tv_n ? h_idx_n : 2'd0;
      tile_row    <= tv_n ? v_idx_n : 2'd0;
      tile_h_cnt  <= tv_n ? h_off_n : 12'd0;
      tile_v_cnt  <= tv_n ? v_off_n : 12'd0;
    end
  end

  assign vif.h_cnt       = h_cnt;
  assign vif.v_cnt       = v_cnt;
  assign vif.hsync       = hsync;
  assign vif.vsync       = vsync;
  assign vif.active      = active;
  assign vif.frame_start = frame_start;
  assign vif.tile_valid  = tile_valid;
  assign vif.tile_col    = tile_col;
  assign vif.tile_row    = tile_row;
  assign vif.tile_h_cnt  = tile_h_cnt;
  assign vif.tile_v_cnt  = tile_v_cnt;

endmodule

// File: tb/tb_vga_tile_timing.sv
// tb/tb_vga_tile_timing.sv - randomized self-checking bench for vga_tile_timing against a coordinate model
module tb_vga_tile_timing;

  // Reduced geometry for a second instance so whole frames fit the run.
  localparam int S_HA = 40, S_HFP = 4, S_HS = 6, S_HBP = 6;
  localparam int S_VA = 36, S_VFP = 2, S_VS = 2, S_VBP = 3;
  localparam int S_TILE = 6, S_GAP = 2, S_X0 = 4, S_Y0 = 2;

  typedef struct {
    int h_act, h_fp, h_sync, h_bp;
    int v_act, v_fp, v_sync, v_bp;
    int tile, gap, x0, y0;
  } cfg_t;

  typedef struct {
    int hsync, vsync, active, fs, tv, col, row, th, tvc;
  } exp_t;

  logic clk;
  logic rst;
  logic pix_en;

  vga_tile_timing_if bif();
  vga_tile_timing_if sif();
  assign bif.pix_en = pix_en;
  assign sif.pix_en = pix_en;

  vga_tile_timing u_big (
    .clk (clk),
    .rst (rst),
    .vif (bif)
  );

  vga_tile_timing #(
    .H_ACTIVE(S_HA), .H_FP(S_HFP), .H_SYNC(S_HS), .H_BP(S_HBP),
    .V_ACTIVE(S_VA), .V_FP(S_VFP), .V_SYNC(S_VS), .V_BP(S_VBP),
    .TILE(S_TILE), .GAP(S_GAP), .BOARD_X0(S_X0), .BOARD_Y0(S_Y0)
  ) u_small (
    .clk (clk),
    .rst (rst),
    .vif (sif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   n_cmp, n_err;
  cfg_t cb, cs;
  int   bh, bv, sh, sv;
  int   s_pix, s_last;
  bit   s_have;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int h_total(input cfg_t c);
    return c.h_act + c.h_fp + c.h_sync + c.h_bp;
  endfunction

  function automatic int v_total(input cfg_t c);
    return c.v_act + c.v_fp + c.v_sync + c.v_bp;
  endfunction

  // Expected outputs for pixel (h,v), straight from the geometry formulas.
  function automatic exp_t model(input cfg_t c, input int h, input int v);
    exp_t e;
    int col, row, th, tvc;
    col = -1; row = -1; th = 0; tvc = 0;
    for (int i = 0; i < 4; i++) begin
      int xs, ys;
      xs = c.x0 + c.gap + i * (c.tile + c.gap);
      ys = c.y0 + c.gap + i * (c.tile + c.gap);
      if (h >= xs && h < xs + c.tile) begin col = i; th = h - xs; end
      if (v >= ys && v < ys + c.tile) begin row = i; tvc = v - ys; end
    end
    e.hsync  = (h >= c.h_act + c.h_fp && h < c.h_act + c.h_fp + c.h_sync) ? 0 : 1;
    e.vsync  = (v >= c.v_act + c.v_fp && v < c.v_act + c.v_fp + c.v_sync) ? 0 : 1;
    e.active = (h < c.h_act && v < c.v_act) ? 1 : 0;
    e.fs     = (h == 0 && v == 0) ? 1 : 0;
    e.tv     = (col >= 0 && row >= 0) ? 1 : 0;
    e.col    = e.tv ? col : 0;
    e.row    = e.tv ? row : 0;
    e.th     = e.tv ? th : 0;
    e.tvc    = e.tv ? tvc : 0;
    return e;
  endfunction

  task automatic check_dut(input string nm, input cfg_t c, input int h, input int v,
                           input logic [11:0] o_h, input logic [11:0] o_v,
                           input logic o_hs, input logic o_vs, input logic o_act,
                           input logic o_fs, input logic o_tv,
                           input logic [1:0] o_col, input logic [1:0] o_row,
                           input logic [11:0] o_th, input logic [11:0] o_tvc);
    exp_t e;
    e = model(c, h, v);
    check_val({nm, ".h_cnt"},       32'(o_h),   h);
    check_val({nm, ".v_cnt"},       32'(o_v),   v);
    check_val({nm, ".hsync"},       32'(o_hs),  e.hsync);
    check_val({nm, ".vsync"},       32'(o_vs),  e.vsync);
    check_val({nm, ".active"},      32'(o_act), e.active);
    check_val({nm, ".frame_start"}, 32'(o_fs),  e.fs);
    check_val({nm, ".tile_valid"},  32'(o_tv),  e.tv);
    check_val({nm, ".tile_col"},    32'(o_col), e.col);
    check_val({nm, ".tile_row"},    32'(o_row), e.row);
    check_val({nm, ".tile_h_cnt"},  32'(o_th),  e.th);
    check_val({nm, ".tile_v_cnt"},  32'(o_tvc), e.tvc);
  endtask

  // One clock: drive at negedge, sample 1 ns after the posedge, advance the
  // models and compare both instances.
  task automatic tick(input logic en, input logic r);
    @(negedge clk);
    pix_en = en;
    rst    = r;
    @(posedge clk);
    #1;
    if (!r) begin
      bh = h_total(cb) - 1; bv = v_total(cb) - 1;
      sh = h_total(cs) - 1; sv = v_total(cs) - 1;
      s_have = 1'b0;
    end else if (en) begin
      bh = (bh + 1) % h_total(cb);
      if (bh == 0) bv = (bv + 1) % v_total(cb);
      sh = (sh + 1) % h_total(cs);
      if (sh == 0) sv = (sv + 1) % v_total(cs);
      s_pix++;
      if (sif.frame_start === 1'b1) begin
        if (s_have) check_val("small.frame_period", 32'(s_pix - s_last), h_total(cs) * v_total(cs));
        s_last = s_pix;
        s_have = 1'b1;
      end
    end
    check_dut("big", cb, bh, bv, bif.h_cnt, bif.v_cnt, bif.hsync, bif.vsync, bif.active,
              bif.frame_start, bif.tile_valid, bif.tile_col, bif.tile_row,
              bif.tile_h_cnt, bif.tile_v_cnt);
    check_dut("small", cs, sh, sv, sif.h_cnt, sif.v_cnt, sif.hsync, sif.vsync, sif.active,
              sif.frame_start, sif.tile_valid, sif.tile_col, sif.tile_row,
              sif.tile_h_cnt, sif.tile_v_cnt);
  endtask

  initial begin
    int  cyc;
    bit  held;
    n_cmp = 0; n_err = 0;
    cb = '{640, 16, 96, 48, 480, 10, 2, 33, 106, 8, 88, 8};
    cs = '{S_HA, S_HFP, S_HS, S_HBP, S_VA, S_VFP, S_VS, S_VBP, S_TILE, S_GAP, S_X0, S_Y0};
    bh = 799; bv = 524; sh = 0; sv = 0;
    s_pix = 0; s_last = 0; s_have = 1'b0;
    rst = 1'b0; pix_en = 1'b0;

    repeat (3) tick(1'b0, 1'b0);
    tick(1'b1, 1'b0);
    check_val("rst.h_cnt", 32'(bif.h_cnt), 799);
    check_val("rst.v_cnt", 32'(bif.v_cnt), 524);
    check_val("rst.hsync", 32'(bif.hsync), 1);

    tick(1'b1, 1'b1);
    check_val("first.frame_start", 32'(bif.frame_start), 1);
    check_val("first.active",      32'(bif.active), 1);
    check_val("first.tile_valid",  32'(bif.tile_valid), 0);
    tick(1'b1, 1'b1);
    check_val("second.frame_start", 32'(bif.frame_start), 0);

    // Random-strobe run down to line 18 of the full-size frame.
    cyc = 0; held = 1'b0;
    while (bv != 18 && cyc < 40000) begin
      if (bv == 16 && bh == 150 && !held) begin
        repeat (20) tick(1'b0, 1'b1);
        tick(1'b1, 1'b1);
        check_val("hold.advance", 32'(bif.h_cnt), 151);
        held = 1'b1;
      end else begin
        tick(($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0, 1'b1);
      end
      if (bv == 16 && bh == 95)  check_val("v16.h95.tile_valid", 32'(bif.tile_valid), 0);
      if (bv == 16 && bh == 96)  check_val("v16.h96.tile_h",     32'(bif.tile_h_cnt), 0);
      if (bv == 16 && bh == 201) check_val("v16.h201.tile_h",    32'(bif.tile_h_cnt), 105);
      if (bv == 16 && bh == 202) check_val("v16.h202.tile_valid", 32'(bif.tile_valid), 0);
      if (bv == 16 && bh == 210) check_val("v16.h210.tile_col",  32'(bif.tile_col), 1);
      cyc++;
    end
    check_val("reach.v18", 32'(bif.v_cnt), 18);

    // Mid-frame reset, then restart from (0,0).
    tick(1'b1, 1'b0);
    check_val("midrst.h_cnt", 32'(bif.h_cnt), 799);
    check_val("midrst.v_cnt", 32'(bif.v_cnt), 524);
    check_val("midrst.vsync", 32'(bif.vsync), 1);
    repeat (2) tick(1'b0, 1'b1);
    tick(1'b1, 1'b1);
    check_val("midrst.frame_start", 32'(bif.frame_start), 1);
    check_val("midrst.h0", 32'(bif.h_cnt), 0);

    for (int i = 0; i < 6000; i++) begin
      tick(($urandom_range(0, 4) != 0) ? 1'b1 : 1'b0, 1'b1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
